dma_block_writer: RTL
=====================

// Module: dma_block_writer
// PURPOSE
//  Write-back initiator for the DMA memory port. Captures one output block (up to BLOCK_SIZE words,
//  parallel bus from the conv/pool engine) and serialises it into main memory as single-word writes
//  (enable=1, RW=0) along a 2-D tile pattern: ROW_LEN words per row, rows row_stride apart.
//  Sits between the CNN output stage and the memory arbiter; the DMA read path is its counterpart.
// PARAMETERS
//  ADDR_WIDTH  16  memory address width
//  DATA_WIDTH  16  signed word width
//  BLOCK_SIZE  25  max words per block (one output tile)
//  ROW_LEN     5   words per tile row before row_stride is applied
// PORTS
//  clk         in   1                       single clock, all logic on posedge
//  rst         in   1                       synchronous, active-high reset
//  start       in   1                       request; sampled only in IDLE
//  base_addr   in   ADDR_WIDTH              address of word 0
//  row_stride  in   ADDR_WIDTH              address delta between row starts (unsigned)
//  length      in   $clog2(BLOCK_SIZE+1)    words to write, 0..BLOCK_SIZE
//  block_in    in   BLOCK_SIZE*DATA_WIDTH   word j at [j*DATA_WIDTH +: DATA_WIDTH]
//  mem_grant   in   1                       arbiter accepts the write presented this cycle
//  mem_enable  out  1                       write request valid
//  mem_rw      out  1                       constant 0 (write) while mem_enable=1; 1 otherwise
//  mem_address out  ADDR_WIDTH              target address
//  mem_data    out  DATA_WIDTH              word to write
//  busy        out  1                       high from cycle after accepted start until done
//  done        out  1                       one-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; mem_enable=0, mem_rw=1, mem_address=0, mem_data=0, busy=0, done=0; word/row/col
//   counters=0. Reset mid-transfer aborts immediately: no further writes, no done pulse.
//  FSM IDLE -> WRITE -> DONE -> IDLE.
//  IDLE: on start=1 latch block_in, base_addr, row_stride, length (clamped to BLOCK_SIZE if larger)
//   into registers; inputs may change afterwards. length=0 -> go to DONE (no writes); else WRITE.
//  WRITE: present word k: mem_enable=1, mem_rw=0, mem_data=buf[k],
//   mem_address = base + row*row_stride + col, row=k/ROW_LEN, col=k%ROW_LEN (counters, no divider).
//   Transfer occurs on a cycle with mem_enable=1 and mem_grant=1; then k++, col++, col wraps 0 at
//   ROW_LEN with row++. mem_grant=0: hold all outputs stable (stall), no loss/duplication.
//   After transfer of word length-1 -> DONE; mem_enable drops the following cycle.
//  DONE: done=1 for exactly one cycle, busy=0, mem_enable=0; -> IDLE. start here is ignored.
//  Latency: first write presented cycle after start; with grant tied high, N words take N cycles
//   in WRITE, done asserted cycle N+1 after start (N>0), cycle 1 for N=0.
//  start while busy/done: ignored, no queuing. Back-to-back: next start accepted in IDLE.
//  Address arithmetic modulo 2^ADDR_WIDTH (wraps silently past 16'hFFFF). Data written unmodified
//   (signed two's complement, no saturation). mem_address/mem_data registered outputs.
// STRUCTURE
//  Package cnn_mem_pkg: ADDR_WIDTH, DATA_WIDTH, BLOCK_SIZE, ROW_LEN constants; typedef word_t,
//   addr_t; enum wr_state_t {IDLE, WRITE, DONE}.
//  One sub-module: tile_addr_gen (clk, rst, load, step, base, stride -> addr): row/col counters and
//   row-base accumulator; FSM + block buffer stay in top.
// TESTING
//  1 grant=1, base=0x0100, stride=5, length=25, block_in[j]=j+1 -> writes 0x0100..0x0118 data 1..25,
//    one per cycle, done pulse cycle 26, exactly 25 enable cycles.
//  2 stride=32, base=0x0040, length=7 -> addrs 0x40..0x44, 0x60, 0x61; data match block words 0..6.
//  3 grant toggles 1,0,0,1... -> outputs frozen during grant=0; each word written once, order kept.
//  4 length=0 -> no mem_enable, done at cycle 1; length=31 -> clamped, exactly 25 writes.
//  5 base=0xFFFE, length=4, stride=5 -> addrs 0xFFFE,0xFFFF,0x0000,0x0001.
//  6 rst asserted after 10 words -> next cycle all outputs at reset values, no done; restart works;
//    start pulses while busy ignored (write count unchanged).

Source files
------------

// File: rtl/cnn_mem_pkg.sv
// Shared constants and types for the CNN memory-port blocks.
//   ADDR_WIDTH / DATA_WIDTH : memory address and signed data widths
//   BLOCK_SIZE              : max words per output tile
//   ROW_LEN                 : words per tile row before the row stride applies
//   word_t / addr_t / len_t : data word, address and word-count types
//   wr_state_t              : block-writer FSM states
package cnn_mem_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int BLOCK_SIZE = 25;
  localparam int ROW_LEN    = 5;

  localparam int LEN_WIDTH  = $clog2(BLOCK_SIZE + 1);
  localparam int COL_WIDTH  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  typedef logic signed [DATA_WIDTH-1:0] word_t;
  typedef logic        [ADDR_WIDTH-1:0] addr_t;
  typedef logic        [LEN_WIDTH-1:0]  len_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } wr_state_t;

  // Requests longer than one tile are truncated to a full tile.
  function automatic len_t clamp_len(input len_t len);
    return (len > len_t'(BLOCK_SIZE)) ? len_t'(BLOCK_SIZE) : len;
  endfunction

endpackage

// File: rtl/dma_block_writer_tile_addr_gen.sv
// tile_addr_gen: walks a 2-D tile address pattern, ROW_LEN words per row with
// rows 'stride' apart. No divider: a column counter plus a row-base accumulator.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture base/stride, address = base (word 0)
//   step     : advance to the next word of the tile
//   base     : address of word 0
//   stride   : address delta between row starts
//   addr     : registered address of the current word
module tile_addr_gen
  import cnn_mem_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  step,
  input  addr_t base,
  input  addr_t stride,
  output addr_t addr
);

  logic [COL_WIDTH-1:0] col_reg;
  addr_t                row_base_reg;
  addr_t                stride_reg;
  addr_t                addr_reg;

  // Address math is modulo 2^ADDR_WIDTH; overflow simply wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg      <= '0;
      row_base_reg <= '0;
      stride_reg   <= '0;
      addr_reg     <= '0;
    end else if (load) begin
      col_reg      <= '0;
      row_base_reg <= base;
      stride_reg   <= stride;
      addr_reg     <= base;
    end else if (step) begin
      if (col_reg == COL_WIDTH'(ROW_LEN - 1)) begin
        col_reg      <= '0;
        row_base_reg <= row_base_reg + stride_reg;
        addr_reg     <= row_base_reg + stride_reg;
      end else begin
        col_reg  <= col_reg + COL_WIDTH'(1);
        addr_reg <= addr_reg + addr_t'(1);
      end
    end
  end

  assign addr = addr_reg;

endmodule

// File: rtl/dma_block_writer.sv
// dma_block_writer: captures one output tile from the conv/pool engine and
// writes it to memory as single-word writes along a 2-D tile pattern.
//   clk, rst     : clock, synchronous active-high reset (aborts a transfer)
//   start        : request, only sampled in IDLE
//   base_addr    : address of word 0
//   row_stride   : address delta between row starts
//   length       : words to write (clamped to BLOCK_SIZE)
//   block_in     : word j at [j*DATA_WIDTH +: DATA_WIDTH]
//   mem_grant    : arbiter accepts the presented write this cycle
//   mem_enable   : write request valid
//   mem_rw       : 0 while writing, 1 otherwise
//   mem_address  : target address (registered)
//   mem_data     : word to write (registered)
//   busy         : transfer in progress
//   done         : one-cycle completion pulse
module dma_block_writer
  import cnn_mem_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  addr_t                            base_addr,
  input  addr_t                            row_stride,
  input  len_t                             length,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] block_in,
  input  logic                             mem_grant,
  output logic                             mem_enable,
  output logic                             mem_rw,
  output addr_t                            mem_address,
  output word_t                            mem_data,
  output logic                             busy,
  output logic                             done
);

  wr_state_t state_reg;
  len_t      len_reg;
  len_t      word_reg;
  len_t      word_next;
  len_t      len_clamped;
  word_t     word_in [BLOCK_SIZE];
  word_t     blk_reg [BLOCK_SIZE];

  logic accept;
  logic xfer;
  logic last_word;
  logic step;

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_unpack
      assign word_in[gi] = block_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign len_clamped = clamp_len(length);
  assign accept      = (state_reg == IDLE) && start;
  assign xfer        = (state_reg == WRITE) && mem_grant;
  assign last_word   = (word_reg == len_reg - len_t'(1));
  assign word_next   = word_reg + len_t'(1);
  // The address generator advances in lock-step with the word counter and
  // stays parked on the last address once the final word is accepted.
  assign step        = xfer && !last_word;

  // Block buffer: snapshot of the tile, so block_in may change after start.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        blk_reg[i] <= word_in[i];
      end
    end
  end

  tile_addr_gen u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (step),
    .base   (base_addr),
    .stride (row_stride),
    .addr   (mem_address)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      len_reg    <= '0;
      word_reg   <= '0;
      mem_enable <= 1'b0;
      mem_rw     <= 1'b1;
      mem_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            len_reg  <= len_clamped;
            word_reg <= '0;
            if (len_clamped == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              // Word 0 is presented the cycle right after start, straight
              // from the input bus since the buffer loads on this same edge.
              state_reg  <= WRITE;
              busy       <= 1'b1;
              mem_enable <= 1'b1;
              mem_rw     <= 1'b0;
              mem_data   <= word_in[0];
            end
          end
        end

        WRITE: begin
          // Without a grant nothing changes: the request is held as-is.
          if (mem_grant) begin
            if (last_word) begin
              state_reg  <= DONE;
              mem_enable <= 1'b0;
              mem_rw     <= 1'b1;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              word_reg <= word_next;
              mem_data <= blk_reg[word_next];
            end
          end
        end

        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
